// File: rtl/ball_str_render.sv
// Ball tracker on the VGA pixel stream: moves once per frame, bounces off top/bottom,
// reports left/right misses, and re-emits the stream one cycle late with a ball flag.
module ball_str_render #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic        px_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [22:0] strVGA_in,
  output logic [22:0] strVGA_out,
  output logic        ball_px,
  output logic        miss_left,
  output logic        miss_right
);

  localparam logic [9:0]  BX_CTR     = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  BY_CTR     = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  BY_LIM     = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] BX_LIM11   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] BY_LIM11   = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  SPD        = 10'(SPEED);
  localparam logic [10:0] SPD11      = 11'(SPEED);
  localparam logic [10:0] BSZ11      = 11'(BALL_SIZE);
  localparam logic [7:0]  SERVE_INIT = 8'(SERVE_FRAMES);

  typedef enum logic {ST_SERVE = 1'b0, ST_PLAY = 1'b1} state_t;

  state_t      r_state;
  logic [9:0]  r_bx;
  logic [9:0]  r_by;
  logic        r_dx_left;
  logic        r_dy_up;
  logic [7:0]  r_serve_cnt;

  logic [10:0] w_x;
  logic [10:0] w_y;
  logic        w_av;
  logic        w_tick;
  logic        w_in_ball;
  logic        w_miss_l;
  logic        w_miss_r;
  logic        w_top;
  logic        w_bot;

  // 11-bit compares keep bx+BALL_SIZE and bx+SPEED from wrapping near the right edge
  assign w_x       = {1'b0, strVGA_in[9:0]};
  assign w_y       = {1'b0, strVGA_in[19:10]};
  assign w_av      = strVGA_in[22];
  assign w_tick    = enable && (strVGA_in[19:10] == 10'(V_ACTIVE)) && (strVGA_in[9:0] == 10'd0);
  assign w_in_ball = w_av
                     && (w_x >= {1'b0, r_bx}) && (w_x < ({1'b0, r_bx} + BSZ11))
                     && (w_y >= {1'b0, r_by}) && (w_y < ({1'b0, r_by} + BSZ11));
  assign w_miss_l  = r_dx_left && (r_bx <= SPD);
  assign w_miss_r  = !r_dx_left && (({1'b0, r_bx} + SPD11) >= BX_LIM11);
  assign w_top     = r_dy_up && (r_by <= SPD);
  assign w_bot     = !r_dy_up && (({1'b0, r_by} + SPD11) >= BY_LIM11);

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      strVGA_out  <= '0;
      ball_px     <= 1'b0;
      miss_left   <= 1'b0;
      miss_right  <= 1'b0;
      r_state     <= ST_SERVE;
      r_serve_cnt <= SERVE_INIT;
      r_bx        <= BX_CTR;
      r_by        <= BY_CTR;
      r_dx_left   <= 1'b0;
      r_dy_up     <= 1'b0;
    end else begin
      // Stream stage: one-cycle pass-through plus pixel-aligned ball flag
      strVGA_out <= strVGA_in;
      ball_px    <= w_in_ball;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_SERVE: begin
            if (r_serve_cnt == 8'd0) r_state <= ST_PLAY;
            else                     r_serve_cnt <= r_serve_cnt - 8'd1;
          end
          ST_PLAY: begin
            if (w_miss_l || w_miss_r) begin
              // A miss wins over any vertical bounce on the same tick; dy is kept
              miss_left   <= w_miss_l;
              miss_right  <= w_miss_r;
              r_bx        <= BX_CTR;
              r_by        <= BY_CTR;
              r_dx_left   <= w_miss_r;
              r_serve_cnt <= SERVE_INIT;
              r_state     <= ST_SERVE;
            end else begin
              r_bx <= r_dx_left ? (r_bx - SPD) : (r_bx + SPD);
              if (w_top) begin
                r_by    <= 10'd0;
                r_dy_up <= 1'b0;
              end else if (w_bot) begin
                r_by    <= BY_LIM;
                r_dy_up <= 1'b1;
              end else begin
                r_by <= r_dy_up ? (r_by - SPD) : (r_by + SPD);
              end
            end
          end
          default: r_state <= ST_SERVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ball_str_render.sv
// Bench for ball_str_render: a full-size instance and a small-field instance are
// driven pixel by pixel and compared against an integer model of the ball rules.
module tb_ball_str_render;

  logic        px_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic [22:0] si[2];
  logic [22:0] so[2];
  logic        bp[2];
  logic        ml[2];
  logic        mr[2];

  int n_chk = 0;
  int n_err = 0;

  int P_H[2]  = '{640, 24};
  int P_V[2]  = '{480, 24};
  int P_SF[2] = '{60, 1};
  int P_B     = 8;
  int P_S     = 2;

  int m_bx[2], m_by[2], m_vx[2], m_vy[2], m_cnt[2];
  bit m_play[2], e_ml[2], e_mr[2];

  always #5 px_clk = ~px_clk;

  ball_str_render u_big (
    .px_clk(px_clk), .rst_n(rst_n), .enable(enable), .strVGA_in(si[0]),
    .strVGA_out(so[0]), .ball_px(bp[0]), .miss_left(ml[0]), .miss_right(mr[0])
  );

  ball_str_render #(.H_ACTIVE(24), .V_ACTIVE(24), .BALL_SIZE(8), .SPEED(2), .SERVE_FRAMES(1)) u_small (
    .px_clk(px_clk), .rst_n(rst_n), .enable(enable), .strVGA_in(si[1]),
    .strVGA_out(so[1]), .ball_px(bp[1]), .miss_left(ml[1]), .miss_right(mr[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bx[k] = (P_H[k] - P_B) / 2;
      m_by[k] = (P_V[k] - P_B) / 2;
      m_vx[k] = P_S;
      m_vy[k] = P_S;
      m_cnt[k] = P_SF[k];
      m_play[k] = 0;
      e_ml[k] = 0;
      e_mr[k] = 0;
    end
  endtask

  task automatic model_tick(input int k, input bit en);
    int nx, ny;
    e_ml[k] = 0;
    e_mr[k] = 0;
    if (!en) return;
    if (!m_play[k]) begin
      if (m_cnt[k] == 0) m_play[k] = 1;
      else m_cnt[k]--;
      return;
    end
    nx = m_bx[k] + m_vx[k];
    if (nx <= 0 || nx >= P_H[k] - P_B) begin
      e_ml[k] = (nx <= 0);
      e_mr[k] = (nx > 0);
      m_bx[k] = (P_H[k] - P_B) / 2;
      m_by[k] = (P_V[k] - P_B) / 2;
      m_vx[k] = -m_vx[k];
      m_cnt[k] = P_SF[k];
      m_play[k] = 0;
    end else begin
      m_bx[k] = nx;
      ny = m_by[k] + m_vy[k];
      if (ny <= 0) begin
        m_by[k] = 0;
        m_vy[k] = P_S;
      end else if (ny >= P_V[k] - P_B) begin
        m_by[k] = P_V[k] - P_B;
        m_vy[k] = -P_S;
      end else begin
        m_by[k] = ny;
      end
    end
  endtask

  // One pixel into instance k; outputs checked #1 after the capturing edge
  task automatic step(input int k, input int x, input int y, input bit av, input string tag);
    logic [9:0]  xv, yv;
    logic [22:0] v;
    bit          eb;
    xv = x[9:0];
    yv = y[9:0];
    v  = {av, 1'($urandom), 1'($urandom), yv, xv};
    si[k]     = v;
    si[1 - k] = 23'd0;
    eb = av && (int'(xv) >= m_bx[k]) && (int'(xv) < m_bx[k] + P_B)
            && (int'(yv) >= m_by[k]) && (int'(yv) < m_by[k] + P_B);
    if (int'(yv) == P_V[k] && xv == 10'd0) model_tick(k, enable);
    else begin
      e_ml[k] = 0;
      e_mr[k] = 0;
    end
    @(posedge px_clk);
    #1;
    chk({tag, "/out"}, 32'(so[k]), 32'(v));
    chk({tag, "/ball_px"}, 32'(bp[k]), 32'(eb));
    chk({tag, "/miss_left"}, 32'(ml[k]), 32'(e_ml[k]));
    chk({tag, "/miss_right"}, 32'(mr[k]), 32'(e_mr[k]));
  endtask

  task automatic tick(input int k, input string tag);
    step(k, 0, P_V[k], 0, tag);
  endtask

  task automatic tick_probe(input int k);
    tick(k, "tick");
    step(k, m_bx[k], m_by[k], 1, "in_tl");
    step(k, m_bx[k] + 7, m_by[k] + 7, 1, "in_br");
    step(k, m_bx[k] + 8, m_by[k], 1, "out_r");
    step(k, m_bx[k] - 1, m_by[k] + 3, 1, "out_l");
    step(k, m_bx[k], m_by[k] - 1, 1, "out_t");
  endtask

  initial begin
    si[0] = 23'd0;
    si[1] = 23'd0;
    model_reset();
    repeat (3) @(posedge px_clk);
    #1;
    chk("rst/out", 32'(so[0]), 32'd0);
    chk("rst/ball_px", 32'(bp[0]), 32'd0);
    chk("rst/miss_left", 32'(ml[0]), 32'd0);
    chk("rst/miss_right", 32'(mr[0]), 32'd0);
    #3 rst_n = 1'b1;
    @(posedge px_clk);
    #1;

    step(0, 316, 236, 1, "centre");
    chk("centre_hit", 32'(bp[0]), 32'd1);
    step(0, 324, 236, 1, "right_of_ball");
    chk("right_of_ball_clear", 32'(bp[0]), 32'd0);
    step(0, 315, 236, 1, "left_of_ball");
    chk("left_of_ball_clear", 32'(bp[0]), 32'd0);
    step(0, 316, 236, 0, "blanked");
    chk("blanked_clear", 32'(bp[0]), 32'd0);

    enable = 1'b1;
    for (int i = 0; i < 60; i++) tick_probe(0);
    step(0, 316, 236, 1, "serve60");
    chk("serve60_centre", 32'(bp[0]), 32'd1);
    tick(0, "tick61");
    step(0, 316, 236, 1, "play_start");
    chk("play_start_still", 32'(bp[0]), 32'd1);
    tick(0, "tick62");
    step(0, 318, 238, 1, "first_move");
    chk("first_move_hit", 32'(bp[0]), 32'd1);
    step(0, 317, 238, 1, "first_move_l");
    chk("first_move_left_clear", 32'(bp[0]), 32'd0);

    for (int i = 0; i < 400 && !(m_by[0] == 470 && m_vy[0] > 0); i++) tick_probe(0);
    tick(0, "bottom_bounce");
    step(0, m_bx[0], 471, 1, "bottom_above");
    chk("bottom_above_clear", 32'(bp[0]), 32'd0);
    step(0, m_bx[0], 472, 1, "bottom_at");
    chk("bottom_at_hit", 32'(bp[0]), 32'd1);
    tick(0, "after_bounce");
    step(0, m_bx[0], 470, 1, "bounced_up");
    chk("bounced_up_hit", 32'(bp[0]), 32'd1);
    step(0, m_bx[0], 478, 1, "bounced_below");
    chk("bounced_below_clear", 32'(bp[0]), 32'd0);

    for (int i = 0; i < 400 && !(m_bx[0] == 630 && m_vx[0] > 0); i++) tick_probe(0);
    tick(0, "right_miss");
    chk("miss_right_pulse", 32'(mr[0]), 32'd1);
    chk("miss_left_quiet", 32'(ml[0]), 32'd0);
    step(0, 316, 236, 1, "after_miss");
    chk("miss_right_one_cycle", 32'(mr[0]), 32'd0);
    chk("recentred", 32'(bp[0]), 32'd1);

    enable = 1'b0;
    for (int i = 0; i < 10; i++) tick_probe(0);
    step(0, 316, 236, 1, "frozen");
    chk("frozen_centre", 32'(bp[0]), 32'd1);
    enable = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        enable = ($urandom_range(0, 3) != 0);
        tick(0, "rnd_tick");
      end else if (r < 8) begin
        step(0, m_bx[0] + $urandom_range(0, 11) - 2, m_by[0] + $urandom_range(0, 11) - 2,
             1'($urandom), "rnd_near");
      end else begin
        step(0, $urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom), "rnd_any");
      end
    end

    enable = 1'b1;
    for (int i = 0; i < 5; i++) tick_probe(1);
    tick(1, "corner_right");
    chk("corner_right_miss", 32'(mr[1]), 32'd1);
    chk("corner_right_no_left", 32'(ml[1]), 32'd0);
    step(1, 8, 8, 1, "corner_recentre");
    chk("corner_recentre_hit", 32'(bp[1]), 32'd1);
    for (int i = 0; i < 3; i++) tick(1, "small_tick");
    step(1, 6, 10, 1, "dy_kept");
    chk("dy_kept_hit", 32'(bp[1]), 32'd1);
    step(1, 6, 9, 1, "dy_kept_above");
    chk("dy_kept_above_clear", 32'(bp[1]), 32'd0);
    for (int i = 0; i < 2; i++) tick(1, "small_tick");
    tick(1, "corner_left");
    chk("corner_left_miss", 32'(ml[1]), 32'd1);
    chk("corner_left_no_right", 32'(mr[1]), 32'd0);
    for (int i = 0; i < 3; i++) tick(1, "small_tick");
    step(1, 10, 10, 1, "left_serve");
    chk("left_serve_hit", 32'(bp[1]), 32'd1);
    step(1, 10, 18, 1, "left_serve_below");
    chk("left_serve_below_clear", 32'(bp[1]), 32'd0);

    step(0, m_bx[0], m_by[0], 1, "pre_reset");
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst/out", 32'(so[0]), 32'd0);
    chk("async_rst/ball_px", 32'(bp[0]), 32'd0);
    chk("async_rst/miss_left", 32'(ml[0]), 32'd0);
    chk("async_rst/miss_right", 32'(mr[0]), 32'd0);
    chk("async_rst/out_small", 32'(so[1]), 32'd0);
    repeat (2) @(posedge px_clk);
    #3 rst_n = 1'b1;
    model_reset();
    @(posedge px_clk);
    #1;
    step(0, 316, 236, 1, "post_reset");
    chk("post_reset_centre", 32'(bp[0]), 32'd1);
    tick_probe(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
